ifetch_data_stage: RTL and testbench
====================================

// Module: ifetch_data_stage
// PURPOSE
//  Instruction-fetch data stage; sits directly downstream of the fetch-tag stage.
//  - Compares the tags read by the tag stage against the fetch PC.
//  - On a hit, reads the L1I data SRAM and emits one 32-bit instruction to decode.
//  - On a miss, rewinds and suspends the thread and tracks the miss in a per-line table.
//  - Issues line requests to L2, installs fills, updates the tag stage and wakes waiting threads.
// PARAMETERS
//  NUM_THREADS  4   hardware threads per SM; at most one outstanding miss per thread
//  NUM_WAYS     4   L1I associativity
//  NUM_SETS     64  L1I sets
//  LINE_BYTES   64  cache line size in bytes
//  ADDR_WIDTH   32  PC width; TAG_WIDTH = ADDR_WIDTH - log2(NUM_SETS) - log2(LINE_BYTES)
// PORTS
//  clk                   in   1                     clock
//  reset                 in   1                     reset, asynchronous, active-high
//  ift_valid             in   1                     tag stage presents a fetch this cycle
//  ift_thread_idx        in   log2(NUM_THREADS)     thread of the fetch
//  ift_pc                in   ADDR_WIDTH            fetch PC
//  ift_tags              in   NUM_WAYS*TAG_WIDTH    tags of set ift_pc.set, way 0 in the LSBs
//  ift_way_valid         in   NUM_WAYS              line-valid bits for that set
//  ift_fill_way_oh       in   NUM_WAYS              LRU victim way for the current fill set
//  ifd_fill_set          out  log2(NUM_SETS)        set being filled; the tag stage uses it to pick the victim
//  ifd_cache_miss        out  1                     one-cycle pulse; the tag stage rewinds the PC by 4
//  ifd_thread_idx        out  log2(NUM_THREADS)     thread that missed
//  ifd_update_tag_en     out  1                     write tag and valid in the tag stage
//  ifd_update_way_oh     out  NUM_WAYS              way to write
//  ifd_update_set        out  log2(NUM_SETS)        set to write
//  ifd_update_tag        out  TAG_WIDTH             tag to write
//  ifd_wakeup_mask       out  NUM_THREADS           one-cycle pulse; threads whose line arrived
//  ifd_inst_valid        out  1                     instruction valid to decode
//  ifd_inst              out  32                    instruction word
//  ifd_inst_pc           out  ADDR_WIDTH            PC of the instruction
//  ifd_inst_thread_idx   out  log2(NUM_THREADS)     thread of the instruction
//  l2_req_valid          out  1                     line request to L2
//  l2_req_ready          in   1                     L2 accepts the request
//  l2_req_addr           out  ADDR_WIDTH            line-aligned request address
//  l2_resp_valid         in   1                     fill data valid
//  l2_resp_addr          in   ADDR_WIDTH            line-aligned fill address
//  l2_resp_data          in   LINE_BYTES*8          fill data, byte 0 in the LSBs
// BEHAVIOUR
//  - Reset: every output is 0; all miss entries are invalid; the data SRAM contents are don't-care.
//    A mid-operation reset drops requests in flight; no wakeup is emitted afterwards.
//  - Hit: way_hit[w] = ift_valid & ift_way_valid[w] & (ift_tags[w] == ift_pc.tag).
//    The data SRAM is read at {set, hit way}.
//    ifd_inst_valid, ifd_inst, ifd_inst_pc and ifd_inst_thread_idx assert exactly 1 cycle later.
//    ifd_inst = line word pc[log2(LINE_BYTES)-1:2].
//    More than one hit way is illegal and is caught by an assertion.
//  - Miss: ifd_cache_miss and ifd_thread_idx are registered and pulse 1 cycle after the fetch; no instruction is emitted.
//    Line address = pc & ~(LINE_BYTES-1).
//    If a valid entry holds the same line, set the thread's waiter bit (merge, no new request).
//    Otherwise allocate a free entry {line, waiters = thread, issued = 0}.
//    The table has NUM_THREADS entries, so it never overflows.
//  - Request FSM, one per entry: IDLE -> WAIT_ISSUE -> WAIT_FILL -> IDLE.
//    A round-robin arbiter picks one WAIT_ISSUE entry.
//    l2_req_valid and l2_req_addr stay stable until l2_req_ready.
//    On the handshake the entry moves to WAIT_FILL and the arbiter pointer advances past it.
//  - Fill: l2_resp_valid whose line matches a WAIT_FILL entry:
//    - ifd_fill_set = fill set, combinational in the same cycle.
//    - Write l2_resp_data to the data SRAM at {fill set, ift_fill_way_oh}.
//    - Pulse ifd_update_tag_en with that way, set and tag in the same cycle.
//    - Next cycle, ifd_wakeup_mask = the entry's waiters and the entry returns to IDLE.
//    - A response with no matching WAIT_FILL entry is dropped: no SRAM write, no tag update.
//  - Simultaneous miss and fill of the same line: the tags are stale, so the fetch misses and ifd_cache_miss still pulses.
//    The thread is OR'd into the filling entry's wakeup; no entry is allocated and no request is issued.
//  - Simultaneous hit read and fill write to the same SRAM entry: the write wins.
//    The hit returns the old data, which is legal because a valid line is never the fill victim.
// CONFIGURATION
//  IFD_PERF_COUNTERS_EN defined:
//  - Adds output ports perf_hit_count (32) and perf_miss_count (32).
//  - Each counts hit or miss lookups, saturates at 2^32-1 and resets to 0.
//  IFD_PERF_COUNTERS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Hit: way 2 tag == pc.tag, pc=0x1008 -> next cycle inst_valid=1, inst=word 2 of the line, pc=0x1008.
//  - Cold miss: thread 1, pc=0x2000 -> miss pulse with tidx=1 next cycle; l2_req_addr=0x2000.
//    Response -> update_tag_en same cycle, wakeup_mask=4'b0010 next cycle.
//  - Merge: threads 0 and 3 miss line 0x3040 -> exactly one L2 request; wakeup_mask=4'b1001.
//  - Backpressure: l2_req_ready low for 5 cycles -> valid and addr stable; 4 concurrent misses are issued round-robin.
//  - Miss and fill of the same line in one cycle -> no second request; the thread is woken with the fill.
//  - Stray response -> no tag update; reset with requests in flight -> all outputs 0, no wakeup afterwards.

Source files
------------

// File: rtl/ifetch_data_stage.sv
// ifetch_data_stage: L1I tag compare, data read, miss tracking and L2 line fills.
// Defining IFD_PERF_COUNTERS_EN adds saturating hit/miss counters.
module ifetch_data_stage #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_WIDTH = 32,
  localparam int TIW = $clog2(NUM_THREADS),
  localparam int WIW = $clog2(NUM_WAYS),
  localparam int SW = $clog2(NUM_SETS),
  localparam int OW = $clog2(LINE_BYTES),
  localparam int TW = ADDR_WIDTH - SW - OW,
  localparam int LW = ADDR_WIDTH - OW,
  localparam int WPL = LINE_BYTES / 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ift_valid,
  input  logic [TIW-1:0]           ift_thread_idx,
  input  logic [ADDR_WIDTH-1:0]    ift_pc,
  input  logic [NUM_WAYS*TW-1:0]   ift_tags,
  input  logic [NUM_WAYS-1:0]      ift_way_valid,
  input  logic [NUM_WAYS-1:0]      ift_fill_way_oh,
  output logic [SW-1:0]            ifd_fill_set,
  output logic                     ifd_cache_miss,
  output logic [TIW-1:0]           ifd_thread_idx,
  output logic                     ifd_update_tag_en,
  output logic [NUM_WAYS-1:0]      ifd_update_way_oh,
  output logic [SW-1:0]            ifd_update_set,
  output logic [TW-1:0]            ifd_update_tag,
  output logic [NUM_THREADS-1:0]   ifd_wakeup_mask,
  output logic                     ifd_inst_valid,
  output logic [31:0]              ifd_inst,
  output logic [ADDR_WIDTH-1:0]    ifd_inst_pc,
  output logic [TIW-1:0]           ifd_inst_thread_idx,
  output logic                     l2_req_valid,
  input  logic                     l2_req_ready,
  output logic [ADDR_WIDTH-1:0]    l2_req_addr,
  input  logic                     l2_resp_valid,
  input  logic [ADDR_WIDTH-1:0]    l2_resp_addr,
  input  logic [LINE_BYTES*8-1:0]  l2_resp_data
`ifdef IFD_PERF_COUNTERS_EN
  ,
  output logic [31:0]              perf_hit_count,
  output logic [31:0]              perf_miss_count
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_ISSUE, WAIT_FILL} req_state_t;
  req_state_t state [NUM_THREADS];
  logic [LW-1:0] line [NUM_THREADS];
  logic [NUM_THREADS-1:0] waiters [NUM_THREADS];
  logic [31:0] sram [NUM_SETS*NUM_WAYS][WPL];
  logic [TIW-1:0] rr_ptr, req_idx, pick_idx, alloc_idx, fill_idx;
  logic [NUM_WAYS-1:0] way_hit;
  logic [WIW-1:0] hit_way, fill_way;
  logic [NUM_THREADS-1:0] match, fill_match, tbit;
  logic miss, pick_found, fill_hit, fill_merge;
  logic [LW-1:0] miss_line, resp_line;
  logic [SW-1:0] pc_set, resp_set;
  logic unused_low_bits;
  assign miss_line = ift_pc[ADDR_WIDTH-1:OW];
  assign resp_line = l2_resp_addr[ADDR_WIDTH-1:OW];
  assign pc_set = ift_pc[OW+SW-1:OW];
  assign resp_set = l2_resp_addr[OW+SW-1:OW];
  assign unused_low_bits = ^{ift_pc[1:0], l2_resp_addr[OW-1:0]};
  always_comb begin
    way_hit = '0;
    hit_way = '0;
    fill_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_hit[w] = ift_valid && ift_way_valid[w] && ift_tags[w*TW +: TW] == ift_pc[ADDR_WIDTH-1 -: TW];
      if (way_hit[w]) hit_way = WIW'(w);
      if (ift_fill_way_oh[w]) fill_way = WIW'(w);
    end
  end
  // Lowest free entry is allocated; the filling entry (if any) is unique by line.
  always_comb begin
    match = '0;
    fill_match = '0;
    alloc_idx = '0;
    fill_idx = '0;
    for (int e = NUM_THREADS - 1; e >= 0; e--) begin
      match[e] = state[e] != IDLE && line[e] == miss_line;
      fill_match[e] = l2_resp_valid && state[e] == WAIT_FILL && line[e] == resp_line;
      if (state[e] == IDLE) alloc_idx = TIW'(e);
      if (fill_match[e]) fill_idx = TIW'(e);
    end
  end
  always_comb begin
    pick_found = 1'b0;
    pick_idx = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--)
      if (state[rr_ptr + TIW'(i)] == WAIT_ISSUE) begin
        pick_found = 1'b1;
        pick_idx = rr_ptr + TIW'(i);
      end
  end
  assign miss = ift_valid && !(|way_hit);
  assign fill_hit = |fill_match;
  assign fill_merge = |(match & fill_match);
  assign tbit = NUM_THREADS'(1) << ift_thread_idx;
  assign ifd_fill_set = l2_resp_valid ? resp_set : '0;
  assign ifd_update_tag_en = fill_hit;
  assign ifd_update_way_oh = fill_hit ? ift_fill_way_oh : '0;
  assign ifd_update_set = fill_hit ? resp_set : '0;
  assign ifd_update_tag = fill_hit ? l2_resp_addr[ADDR_WIDTH-1 -: TW] : '0;
  always_ff @(posedge clk)
    if (fill_hit)
      for (int i = 0; i < WPL; i++) sram[{resp_set, fill_way}][i] <= l2_resp_data[i*32 +: 32];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_THREADS; e++) begin
        state[e] <= IDLE;
        line[e] <= '0;
        waiters[e] <= '0;
      end
      rr_ptr <= '0;
      req_idx <= '0;
      l2_req_valid <= 1'b0;
      l2_req_addr <= '0;
      ifd_cache_miss <= 1'b0;
      ifd_thread_idx <= '0;
      ifd_wakeup_mask <= '0;
      ifd_inst_valid <= 1'b0;
      ifd_inst <= '0;
      ifd_inst_pc <= '0;
      ifd_inst_thread_idx <= '0;
    end else begin
      ifd_cache_miss <= miss;
      if (miss) ifd_thread_idx <= ift_thread_idx;
      ifd_inst_valid <= |way_hit;
      if (|way_hit) begin
        ifd_inst <= sram[{pc_set, hit_way}][ift_pc[OW-1:2]];
        ifd_inst_pc <= ift_pc;
        ifd_inst_thread_idx <= ift_thread_idx;
      end
      // A miss on the line being filled rides along with this fill's wakeup.
      ifd_wakeup_mask <= fill_hit ? waiters[fill_idx] | (miss && fill_merge ? tbit : '0) : '0;
      for (int e = 0; e < NUM_THREADS; e++) begin
        if (fill_match[e]) state[e] <= IDLE;
        else if (l2_req_valid && l2_req_ready && req_idx == TIW'(e)) state[e] <= WAIT_FILL;
        if (miss && match[e] && !fill_match[e]) waiters[e] <= waiters[e] | tbit;
        if (miss && !(|match) && alloc_idx == TIW'(e)) begin
          state[e] <= WAIT_ISSUE;
          line[e] <= miss_line;
          waiters[e] <= tbit;
        end
      end
      if (l2_req_valid && l2_req_ready) begin
        l2_req_valid <= 1'b0;
        rr_ptr <= req_idx + TIW'(1);
      end else if (!l2_req_valid && pick_found) begin
        l2_req_valid <= 1'b1;
        req_idx <= pick_idx;
        l2_req_addr <= {line[pick_idx], OW'(0)};
      end
    end
  end
`ifdef IFD_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hit_count <= '0;
      perf_miss_count <= '0;
    end else begin
      if (|way_hit && !(&perf_hit_count)) perf_hit_count <= perf_hit_count + 32'd1;
      if (miss && !(&perf_miss_count)) perf_miss_count <= perf_miss_count + 32'd1;
    end
  end
`endif
  assert property (@(posedge clk) disable iff (reset) $onehot0(way_hit))
    else $error("multiple L1I ways hit");
endmodule

// File: tb/tb_ifetch_data_stage.sv
// tb_ifetch_data_stage: vector table plus scoreboard queues checked by a negedge monitor.
module tb_ifetch_data_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic ift_valid;
  logic [1:0] ift_thread_idx;
  logic [31:0] ift_pc;
  logic [79:0] ift_tags;
  logic [3:0] ift_way_valid, ift_fill_way_oh;
  logic [5:0] ifd_fill_set, ifd_update_set;
  logic ifd_cache_miss, ifd_update_tag_en, ifd_inst_valid;
  logic [1:0] ifd_thread_idx, ifd_inst_thread_idx;
  logic [3:0] ifd_update_way_oh, ifd_wakeup_mask;
  logic [19:0] ifd_update_tag;
  logic [31:0] ifd_inst, ifd_inst_pc;
  logic l2_req_valid, l2_req_ready, l2_resp_valid;
  logic [31:0] l2_req_addr, l2_resp_addr;
  logic [511:0] l2_resp_data;
`ifdef IFD_PERF_COUNTERS_EN
  logic [31:0] perf_hit_count, perf_miss_count;
`endif
  ifetch_data_stage dut (
    .clk(clk), .reset(reset),
    .ift_valid(ift_valid), .ift_thread_idx(ift_thread_idx), .ift_pc(ift_pc),
    .ift_tags(ift_tags), .ift_way_valid(ift_way_valid), .ift_fill_way_oh(ift_fill_way_oh),
    .ifd_fill_set(ifd_fill_set), .ifd_cache_miss(ifd_cache_miss), .ifd_thread_idx(ifd_thread_idx),
    .ifd_update_tag_en(ifd_update_tag_en), .ifd_update_way_oh(ifd_update_way_oh),
    .ifd_update_set(ifd_update_set), .ifd_update_tag(ifd_update_tag),
    .ifd_wakeup_mask(ifd_wakeup_mask), .ifd_inst_valid(ifd_inst_valid), .ifd_inst(ifd_inst),
    .ifd_inst_pc(ifd_inst_pc), .ifd_inst_thread_idx(ifd_inst_thread_idx),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
    .l2_resp_valid(l2_resp_valid), .l2_resp_addr(l2_resp_addr), .l2_resp_data(l2_resp_data)
`ifdef IFD_PERF_COUNTERS_EN
    , .perf_hit_count(perf_hit_count), .perf_miss_count(perf_miss_count)
`endif
  );
  typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic [1:0] tid;} inst_t;
  typedef struct packed {logic [3:0] way; logic [5:0] set; logic [19:0] tag;} upd_t;
  typedef struct packed {logic v; logic [1:0] tid; logic [31:0] pc; logic [79:0] tags; logic [3:0] wv; logic hit;} vec_t;
  inst_t inst_q[$];
  upd_t upd_q[$];
  logic [1:0] miss_q[$];
  logic [31:0] req_q[$];
  logic [3:0] wake_q[$];
  inst_t ie;
  upd_t ue;
  vec_t vecs[9];
  logic [31:0] bp_line[4];
  int n_vec = 0;
  int n_err = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction
  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a & ~32'h3) * 32'h9E3779B1;
  endfunction
  function automatic logic [511:0] line_of(logic [31:0] a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = word_of((a & ~32'h3F) + 32'(i * 4));
    return d;
  endfunction
  function automatic logic [79:0] tags4(logic [19:0] t3, logic [19:0] t2, logic [19:0] t1, logic [19:0] t0);
    return {t3, t2, t1, t0};
  endfunction
  always @(negedge clk) if (!reset) begin
    if (ifd_inst_valid) begin
      chk("inst_expected", 64'(inst_q.size() != 0), 64'd1);
      if (inst_q.size() != 0) begin
        ie = inst_q.pop_front();
        chk("inst", 64'(ifd_inst), 64'(ie.inst));
        chk("inst_pc", 64'(ifd_inst_pc), 64'(ie.pc));
        chk("inst_tid", 64'(ifd_inst_thread_idx), 64'(ie.tid));
      end
    end
    if (ifd_cache_miss) begin
      chk("miss_expected", 64'(miss_q.size() != 0), 64'd1);
      if (miss_q.size() != 0) chk("miss_tid", 64'(ifd_thread_idx), 64'(miss_q.pop_front()));
    end
    if (l2_req_valid && l2_req_ready) begin
      chk("req_expected", 64'(req_q.size() != 0), 64'd1);
      if (req_q.size() != 0) chk("req_addr_order", 64'(l2_req_addr), 64'(req_q.pop_front()));
    end
    if (ifd_update_tag_en) begin
      chk("update_expected", 64'(upd_q.size() != 0), 64'd1);
      if (upd_q.size() != 0) begin
        ue = upd_q.pop_front();
        chk("update", 64'({ifd_update_way_oh, ifd_update_set, ifd_update_tag}), 64'(ue));
      end
    end
    if (ifd_wakeup_mask != 4'd0) begin
      chk("wake_expected", 64'(wake_q.size() != 0), 64'd1);
      if (wake_q.size() != 0) chk("wake_mask", 64'(ifd_wakeup_mask), 64'(wake_q.pop_front()));
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_inst_valid"}, 64'(ifd_inst_valid), 64'd0);
    chk({tag, "_inst"}, 64'(ifd_inst), 64'd0);
    chk({tag, "_inst_pc"}, 64'(ifd_inst_pc), 64'd0);
    chk({tag, "_miss"}, 64'(ifd_cache_miss), 64'd0);
    chk({tag, "_wake"}, 64'(ifd_wakeup_mask), 64'd0);
    chk({tag, "_upd_en"}, 64'(ifd_update_tag_en), 64'd0);
    chk({tag, "_req_valid"}, 64'(l2_req_valid), 64'd0);
    chk({tag, "_req_addr"}, 64'(l2_req_addr), 64'd0);
  endtask
  task automatic fetch_miss(input logic [1:0] tid, input logic [31:0] pc);
    ift_valid = 1'b1;
    ift_thread_idx = tid;
    ift_pc = pc;
    ift_tags = '0;
    ift_way_valid = '0;
    miss_q.push_back(tid);
    step();
    ift_valid = 1'b0;
  endtask
  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 20 && !l2_req_valid; i++) step();
    chk("req_valid", 64'(l2_req_valid), 64'd1);
    chk("req_addr", 64'(l2_req_addr), 64'(a));
  endtask
  task automatic drain();
    l2_req_ready = 1'b1;
    for (int i = 0; i < 40 && req_q.size() != 0; i++) step();
    chk("req_drain", 64'(req_q.size()), 64'd0);
    l2_req_ready = 1'b0;
  endtask
  task automatic fill(input logic [31:0] a, input logic [3:0] way, input logic [3:0] wake);
    l2_resp_valid = 1'b1;
    l2_resp_addr = a;
    l2_resp_data = line_of(a);
    ift_fill_way_oh = way;
    upd_q.push_back({way, a[11:6], a[31:12]});
    wake_q.push_back(wake);
    #1;
    chk("fill_set", 64'(ifd_fill_set), 64'(a[11:6]));
    chk("fill_upd_en", 64'(ifd_update_tag_en), 64'd1);
    step();
    l2_resp_valid = 1'b0;
    chk("wakeup", 64'(ifd_wakeup_mask), 64'(wake));
    step();
    chk("wakeup_pulse", 64'(ifd_wakeup_mask), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ift_valid = 0; ift_thread_idx = 0; ift_pc = 0; ift_tags = 0; ift_way_valid = 0; ift_fill_way_oh = 0;
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_addr = 0; l2_resp_data = 0;
    repeat (3) step();
    chk_reset("por");
    reset = 1'b0;
    step();
    // cold miss, thread 1
    req_q.push_back(32'h2000);
    fetch_miss(2'd1, 32'h2000);
    chk("cold_miss_pulse", 64'(ifd_cache_miss), 64'd1);
    chk("cold_miss_tid", 64'(ifd_thread_idx), 64'd1);
    chk("cold_no_inst", 64'(ifd_inst_valid), 64'd0);
    step();
    chk("cold_miss_one_cycle", 64'(ifd_cache_miss), 64'd0);
    wait_req(32'h2000);
    drain();
    fill(32'h2000, 4'b0001, 4'b0010);
    req_q.push_back(32'h1000);
    fetch_miss(2'd0, 32'h1000);
    drain();
    fill(32'h1000, 4'b0100, 4'b0001);
    // stray response with an empty table
    l2_resp_valid = 1'b1; l2_resp_addr = 32'h6000; l2_resp_data = line_of(32'h6000);
    #1 chk("stray_upd_en", 64'(ifd_update_tag_en), 64'd0);
    step();
    l2_resp_valid = 1'b0;
    chk("stray_no_wake", 64'(ifd_wakeup_mask), 64'd0);
    // merge: threads 0 and 3 on one line
    req_q.push_back(32'h3040);
    fetch_miss(2'd0, 32'h3040);
    fetch_miss(2'd3, 32'h3044);
    drain();
    fill(32'h3040, 4'b0010, 4'b1001);
    // backpressure with four concurrent misses
    bp_line = '{32'h0A40, 32'h4100, 32'h12380, 32'h7FC0};
    for (int t = 0; t < 4; t++) begin
      req_q.push_back(bp_line[t]);
      fetch_miss(2'(t), bp_line[t]);
    end
    wait_req(bp_line[0]);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_stable", 64'(l2_req_valid), 64'd1);
      chk("bp_addr_stable", 64'(l2_req_addr), 64'(bp_line[0]));
      step();
    end
    drain();
    for (int t = 0; t < 4; t++) fill(bp_line[t], 4'(1 << t), 4'(1 << t));
    // miss and fill of the same line in one cycle
    req_q.push_back(32'h5080);
    fetch_miss(2'd2, 32'h5080);
    drain();
    ift_valid = 1'b1; ift_thread_idx = 2'd0; ift_pc = 32'h5084; ift_tags = '0; ift_way_valid = '0;
    miss_q.push_back(2'd0);
    l2_resp_valid = 1'b1; l2_resp_addr = 32'h5080; l2_resp_data = line_of(32'h5080); ift_fill_way_oh = 4'b0001;
    upd_q.push_back({4'b0001, 6'd2, 20'h5});
    wake_q.push_back(4'b0101);
    step();
    ift_valid = 1'b0; l2_resp_valid = 1'b0;
    chk("mf_miss_pulse", 64'(ifd_cache_miss), 64'd1);
    chk("mf_wake", 64'(ifd_wakeup_mask), 64'd5);
    l2_req_ready = 1'b1;
    repeat (5) step();
    chk("mf_no_extra_req", 64'(l2_req_valid), 64'd0);
    l2_req_ready = 1'b0;
    // table-driven hit/miss lookups
    vecs[0] = '{1'b1, 2'd0, 32'h1008, tags4(0, 1, 0, 2), 4'b0101, 1'b1};
    vecs[1] = '{1'b1, 2'd1, 32'h203C, tags4(0, 1, 0, 2), 4'b0101, 1'b1};
    vecs[2] = '{1'b1, 2'd2, 32'h1004, tags4(0, 1, 0, 2), 4'b0001, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 32'h7FC0, tags4(7, 0, 0, 0), 4'b1000, 1'b1};
    vecs[4] = '{1'b1, 2'd0, 32'h0A60, tags4(0, 0, 0, 0), 4'b0001, 1'b1};
    vecs[5] = '{1'b1, 2'd1, 32'h12384, tags4(0, 20'h12, 0, 0), 4'b0100, 1'b1};
    vecs[6] = '{1'b1, 2'd0, 32'h4110, tags4(0, 0, 4, 0), 4'b0010, 1'b1};
    vecs[7] = '{1'b1, 2'd3, 32'h9008, tags4(0, 1, 0, 2), 4'b0101, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 32'h1008, tags4(0, 1, 0, 2), 4'b0101, 1'b0};
    for (int i = 0; i < 9; i++) begin
      ift_valid = vecs[i].v; ift_thread_idx = vecs[i].tid; ift_pc = vecs[i].pc;
      ift_tags = vecs[i].tags; ift_way_valid = vecs[i].wv;
      if (vecs[i].v && vecs[i].hit) inst_q.push_back({word_of(vecs[i].pc), vecs[i].pc, vecs[i].tid});
      if (vecs[i].v && !vecs[i].hit) begin
        miss_q.push_back(vecs[i].tid);
        req_q.push_back(vecs[i].pc & ~32'h3F);
      end
      step();
    end
    ift_valid = 1'b0;
    step();
    step();
    chk("table_inst_drained", 64'(inst_q.size()), 64'd0);
    wait_req(32'h1000);
    // reset with requests in flight
    reset = 1'b1;
    #1 chk_reset("mid");
    req_q.delete();
    step();
    step();
    reset = 1'b0;
    l2_req_ready = 1'b1;
    l2_resp_valid = 1'b1; l2_resp_addr = 32'h1000; l2_resp_data = line_of(32'h1000);
    #1 chk("post_reset_stray_upd", 64'(ifd_update_tag_en), 64'd0);
    step();
    l2_resp_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_reset_no_wake", 64'(ifd_wakeup_mask), 64'd0);
      chk("post_reset_no_req", 64'(l2_req_valid), 64'd0);
      step();
    end
    l2_req_ready = 1'b0;
    chk("end_inst_q", 64'(inst_q.size()), 64'd0);
    chk("end_miss_q", 64'(miss_q.size()), 64'd0);
    chk("end_req_q", 64'(req_q.size()), 64'd0);
    chk("end_upd_q", 64'(upd_q.size()), 64'd0);
    chk("end_wake_q", 64'(wake_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
